redirect_scoreboard: RTL

REDIRECT_SCOREBOARD -- requirements
Module: redirect_scoreboard

---
 rtl/redirect_scoreboard_pkg.sv | 21 ++
 rtl/redirect_port_match.sv | 50 +++++
 rtl/redirect_scoreboard.sv | 99 +++++++++
 3 files changed

// File: rtl/redirect_scoreboard_pkg.sv
// Shared types and defaults for the redirect scoreboard (forwarding / load-use detection).
package redirect_scoreboard_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_AW_DEF     = 5;
    localparam int N_RD_DEF       = 2;
    localparam int FWD_STAGES_DEF = 2;
    localparam int LOAD_LAT_DEF   = 1;

    // Entries carry a fixed-width index so one struct serves every REG_AW <= REG_AW_MAX.
    localparam int REG_AW_MAX = 8;

    localparam logic [REG_AW_MAX-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  we;
        logic [REG_AW_MAX-1:0] rd;
        logic                  is_load;
    } stage_entry_t;

endpackage

// File: rtl/redirect_port_match.sv
// One read port: finds the youngest tracked stage writing rs and picks forward / load-use / regfile.
module redirect_port_match
    import redirect_scoreboard_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_AW     = REG_AW_DEF,
    parameter int FWD_STAGES = FWD_STAGES_DEF,
    parameter int LOAD_LAT   = LOAD_LAT_DEF
) (
    input  stage_entry_t [FWD_STAGES-1:0]   entries,
    input  logic [REG_AW-1:0]               rs,
    input  logic                            rs_used,
    input  logic [FWD_STAGES*DATA_W-1:0]    stage_data,
    input  logic [DATA_W-1:0]               rf_data,
    output logic                            hit,
    output logic [DATA_W-1:0]               data,
    output logic                            load_use
);

    logic [REG_AW_MAX-1:0] rs_ext;
    logic [FWD_STAGES-1:0] match;

    assign rs_ext = REG_AW_MAX'(rs);

    for (genvar gi = 0; gi < FWD_STAGES; gi++) begin : g_match
        assign match[gi] = entries[gi].we && (entries[gi].rd != REG_ZERO)
                           && (entries[gi].rd == rs_ext) && rs_used;
    end

    // Scan youngest first; the first match decides and older stages are ignored.
    always_comb begin
        logic found;
        found    = 1'b0;
        hit      = 1'b0;
        load_use = 1'b0;
        data     = rf_data;
        for (int k = 0; k < FWD_STAGES; k++) begin
            if (match[k] && !found) begin
                found = 1'b1;
                if (entries[k].is_load && ((k + 1) <= LOAD_LAT)) begin
                    load_use = 1'b1;
                end else begin
                    hit  = 1'b1;
                    data = stage_data[k*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/redirect_scoreboard.sv
// Pipeline destination tracker with operand forwarding and load-use stall.
// Optional stall statistics counter enabled by defining REDIRECT_STATS_EN.
module redirect_scoreboard
    import redirect_scoreboard_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_AW     = REG_AW_DEF,
    parameter int N_RD       = N_RD_DEF,
    parameter int FWD_STAGES = FWD_STAGES_DEF,
    parameter int LOAD_LAT   = LOAD_LAT_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          id_valid,
    input  logic [N_RD*REG_AW-1:0]        id_rs,
    input  logic [N_RD-1:0]               id_rs_used,
    input  logic [REG_AW-1:0]             id_rd,
    input  logic                          id_we,
    input  logic                          id_is_load,
    input  logic [FWD_STAGES*DATA_W-1:0]  stage_data,
    input  logic [N_RD*DATA_W-1:0]        rf_data,
    output logic                          stall,
    output logic [N_RD-1:0]               fwd_hit,
    output logic [N_RD*DATA_W-1:0]        fwd_data,
    output logic [31:0]                   stall_cnt
);

    stage_entry_t [FWD_STAGES-1:0] entry_q, entry_d;
    logic [N_RD-1:0]               load_use;

    assign stall = id_valid && (|load_use);

    // A stalled instruction enters EX as a bubble; flush kills every in-flight write.
    always_comb begin
        entry_d         = entry_q;
        entry_d[0].we      = id_we && id_valid && !stall;
        entry_d[0].rd      = REG_AW_MAX'(id_rd);
        entry_d[0].is_load = id_is_load;
        for (int k = 1; k < FWD_STAGES; k++) begin
            entry_d[k] = entry_q[k-1];
        end
        if (flush) begin
            for (int k = 0; k < FWD_STAGES; k++) begin
                entry_d[k].we = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    for (genvar gi = 0; gi < N_RD; gi++) begin : g_port
        redirect_port_match #(
            .DATA_W     (DATA_W),
            .REG_AW     (REG_AW),
            .FWD_STAGES (FWD_STAGES),
            .LOAD_LAT   (LOAD_LAT)
        ) u_match (
            .entries    (entry_q),
            .rs         (id_rs[gi*REG_AW +: REG_AW]),
            .rs_used    (id_rs_used[gi]),
            .stage_data (stage_data),
            .rf_data    (rf_data[gi*DATA_W +: DATA_W]),
            .hit        (fwd_hit[gi]),
            .data       (fwd_data[gi*DATA_W +: DATA_W]),
            .load_use   (load_use[gi])
        );
    end

`ifdef REDIRECT_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
